uart_rx: RTL and testbench

- UART receive stage, directly downstream of the transmitter; consumes the serial line (TX_OUT of the TX side) and recovers parallel words.
- Frame format matches the transmitter: start bit 0, WIDTH data bits LSB-first, optional parity bit, one stop bit 1; line idles high.
- Oversampled by a runtime prescale; delivers a one-cycle data_valid strobe plus per-frame error flags.

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_sampler.sv | 73 +++++++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state codes, legal prescale ratios, default word width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_rx_pkg;

    localparam int UART_WIDTH = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit edge counter and 3-sample majority vote.
// Latency: 2 clocks line-to-rx_s; bit_value resolves at edge count P/2+1.
// Backpressure: none; free-running while run is high.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  rx_s,
    output logic                  bit_value,
    output logic                  sample_done,
    output logic                  bit_end
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic                  sync_q1;
    logic                  sync_q2;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic                  samp_a;
    logic                  samp_b;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= RX_IN;
            sync_q2 <= sync_q1;
        end
    end

    assign rx_s = sync_q2;
    assign half = {1'b0, prescale[PRESCALE_W-1:1]};

    assign bit_end     = run && (edge_cnt == prescale - ONE);
    assign sample_done = run && (edge_cnt == half + ONE);

    // Counter sits at 0 while idle so the first START cycle is count 0.
    always_ff @(posedge CLK) begin
        if (RST || !run) begin
            edge_cnt <= '0;
        end else if (bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (run && edge_cnt == half - ONE) begin
                samp_a <= rx_s;
            end
            if (run && edge_cnt == half) begin
                samp_b <= rx_s;
            end
        end
    end

    // Third vote is the live sample at count P/2+1.
    assign bit_value = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, shift register, parity check, strobes; UART_RX_ERR_CNT_EN adds error counters.
// Latency: data_valid 1 clock after the stop-bit majority decision (3 clocks after sync input).
// Backpressure: none; strobes are single-cycle and cannot be stalled.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int WIDTH      = UART_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [WIDTH-1:0]      P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]            par_err_cnt,
    output logic [7:0]            stop_err_cnt
`endif
);

    localparam int             BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    logic [2:0]            state;
    logic [BCW-1:0]        bit_cnt;
    logic [WIDTH-1:0]      shreg;
    logic [PRESCALE_W-1:0] ps_q;
    logic [PRESCALE_W-1:0] ps_legal;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  par_err;
    logic                  rx_s;
    logic                  bit_value;
    logic                  sample_done;
    logic                  bit_end;

    always_comb begin
        ps_legal = PRESCALE_W'(PRESCALE_8);
        if (prescale == PRESCALE_W'(PRESCALE_16) || prescale == PRESCALE_W'(PRESCALE_32)) begin
            ps_legal = prescale;
        end
    end

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .run         (busy),
        .prescale    (ps_q),
        .rx_s        (rx_s),
        .bit_value   (bit_value),
        .sample_done (sample_done),
        .bit_end     (bit_end)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            ps_q         <= PRESCALE_W'(PRESCALE_8);
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            par_err      <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state      <= START;
                        ps_q       <= ps_legal;
                        par_en_q   <= parity_enable;
                        par_type_q <= parity_type;
                        par_err    <= 1'b0;
                        bit_cnt    <= '0;
                    end
                end
                START: begin
                    if (sample_done && bit_value) begin
                        state <= IDLE;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sample_done) begin
                        shreg <= {bit_value, shreg[WIDTH-1:1]};
                    end
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (sample_done) begin
                        par_err <= (bit_value != ((^shreg) ^ par_type_q));
                    end
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is caught.
                    if (sample_done) begin
                        state        <= IDLE;
                        stop_error   <= ~bit_value;
                        parity_error <= bit_value & par_err;
                        data_valid   <= bit_value & ~par_err;
                        if (bit_value && !par_err) begin
                            P_DATA <= shreg;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_err_cnt  <= 8'd0;
            stop_err_cnt <= 8'd0;
        end else begin
            if (parity_error && par_err_cnt != 8'hFF) begin
                par_err_cnt <= par_err_cnt + 8'd1;
            end
            if (stop_error && stop_err_cnt != 8'hFF) begin
                stop_err_cnt <= stop_err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, directed corner cases, randomized frames vs a frame-level model.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       parity_enable = 1'b0;
    logic       parity_type = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] par_err_cnt;
    logic [7:0] stop_err_cnt;
`endif

    always #5 CLK = ~CLK;

    uart_rx #(
        .WIDTH      (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .prescale      (prescale),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .P_DATA        (P_DATA),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .stop_error    (stop_error),
        .busy          (busy)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .par_err_cnt   (par_err_cnt),
        .stop_err_cnt  (stop_err_cnt)
`endif
    );

    typedef struct {
        logic [5:0] ps;
        logic       pe;
        logic       pt;
        logic [7:0] d;
        logic       pb;
        logic       sb;
        logic [1:0] kind;
        logic [7:0] dat;
    } vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    vec_t       tbl[7];

    // Event codes: 1 = data_valid with data, 2 = parity_error, 3 = stop_error.
    always @(negedge CLK) begin
        if (RST !== 1'b1) begin
            if (data_valid)   got_q.push_back({2'd1, P_DATA});
            if (parity_error) got_q.push_back({2'd2, 8'h00});
            if (stop_error)   got_q.push_back({2'd3, 8'h00});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int eff_p(input logic [5:0] v);
        return (v == 6'd8 || v == 6'd16 || v == 6'd32) ? int'(v) : 8;
    endfunction

    function automatic logic [9:0] model(input logic pe, input logic pt, input logic [7:0] d,
                                         input logic pb, input logic sb);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (!sb) return {2'd3, 8'h00};
        // Even parity wants an even total count of ones, odd wants odd.
        if (pe && (((ones + int'(pb)) % 2) != int'(pt))) return {2'd2, 8'h00};
        return {2'd1, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [5:0] ps, input logic pe, input logic pt,
                              input logic [7:0] d, input logic pb, input logic sb);
        int p;
        p = eff_p(ps);
        prescale = ps;
        parity_enable = pe;
        parity_type = pt;
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        if (pe) send_bit(pb, p);
        send_bit(sb, p);
    endtask

    task automatic check_events(input string name);
        check({name, " event count"}, got_q.size(), exp_q.size());
        if (got_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                check($sformatf("%s event %0d", name, i), got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push_exp(input logic [9:0] e);
        exp_q.push_back(e);
        if (e[9:8] == 2'd1) last_good = e[7:0];
    endtask

    initial begin
        tbl[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd1, 8'hA5};
        tbl[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 2'd1, 8'h3C};
        tbl[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 2'd2, 8'h00};
        tbl[3] = '{6'd32, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 2'd3, 8'h00};
        tbl[4] = '{6'd32, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 2'd1, 8'h81};
        tbl[5] = '{6'd20, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 2'd1, 8'h5A};
        tbl[6] = '{6'd8,  1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 2'd2, 8'h00};

        repeat (4) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset P_DATA", P_DATA, 0);
        check("reset strobes", {data_valid, parity_error, stop_error}, 0);
        check("reset busy", busy, 0);
`ifdef UART_RX_ERR_CNT_EN
        check("reset counters", {par_err_cnt, stop_err_cnt}, 0);
`endif
        idle(4);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].ps, tbl[i].pe, tbl[i].pt, tbl[i].d, tbl[i].pb, tbl[i].sb);
            idle(2 * eff_p(tbl[i].ps) + 6);
            push_exp({tbl[i].kind, tbl[i].dat});
            check_events($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d busy", i), busy, 0);
            check($sformatf("tbl%0d P_DATA", i), P_DATA, last_good);
        end

        // Back-to-back frames with no idle gap.
        send_frame(6'd8, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1);
        send_frame(6'd8, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1);
        send_frame(6'd8, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1);
        idle(20);
        push_exp({2'd1, 8'h11});
        push_exp({2'd1, 8'h22});
        push_exp({2'd1, 8'h33});
        check_events("b2b");
        check("b2b P_DATA", P_DATA, last_good);

        // Two-clock low glitch on an idle line.
        prescale = 6'd16;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        check("glitch busy high", busy, 1);
        repeat (10) @(negedge CLK);
        check("glitch busy low", busy, 0);
        idle(10);
        check_events("glitch");

        // Reset in the middle of a frame.
        prescale = 6'd8;
        parity_enable = 1'b0;
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        RX_IN = 1'b1;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        last_good = 8'h00;
        idle(20);
        check_events("rst abort");
        check("rst abort busy", busy, 0);
        check("rst abort P_DATA", P_DATA, last_good);
        send_frame(6'd8, 1'b0, 1'b0, 8'h66, 1'b0, 1'b1);
        idle(22);
        push_exp({2'd1, 8'h66});
        check_events("after rst");

        // Randomized frames against the frame-level model.
        for (int n = 0; n < 24; n++) begin
            logic [5:0] ps;
            logic       pe, pt, pb, sb;
            logic [7:0] d;
            case ($urandom_range(0, 3))
                0:       ps = 6'd8;
                1:       ps = 6'd16;
                2:       ps = 6'd32;
                default: ps = 6'($urandom_range(0, 63));
            endcase
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 4) != 0);
            d  = 8'($urandom_range(0, 255));
            send_frame(ps, pe, pt, d, pb, sb);
            idle(2 * eff_p(ps) + 6);
            push_exp(model(pe, pt, d, pb, sb));
            check_events($sformatf("rand%0d", n));
            check($sformatf("rand%0d P_DATA", n), P_DATA, last_good);
        end

`ifdef UART_RX_ERR_CNT_EN
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        idle(4);
        for (int n = 0; n < 300; n++) begin
            send_frame(6'd8, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
            idle(2);
            if (n == 9) check("par_err_cnt after 10", par_err_cnt, 10);
        end
        idle(10);
        got_q.delete();
        check("par_err_cnt saturated", par_err_cnt, 255);
        check("stop_err_cnt zero", stop_err_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
